// File: rtl/pipe_hazard_unit_if.sv
// D-stage to hazard-unit bundle: decoder register fields and Tuse/Tnew codes in,
// stall / forward selects / multiply-divide busy back out.
interface pipe_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int T_W    = 2
);
    logic              d_valid;
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [T_W-1:0]    d_tuse_rs;
    logic [T_W-1:0]    d_tuse_rt;
    logic              d_wr_en;
    logic [REG_AW-1:0] d_wr_addr;
    logic [T_W-1:0]    d_tnew;
    logic              d_md_start;
    logic              d_md_div;
    logic              d_md_use;
    logic              e_flush;
    logic              stall;
    logic [2:0]        fwd_rs_sel;
    logic [2:0]        fwd_rt_sel;
    logic              md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr_en, d_wr_addr, d_tnew,
               d_md_start, d_md_div, d_md_use, e_flush,
        input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr_en, d_wr_addr, d_tnew,
               d_md_start, d_md_div, d_md_use, e_flush,
        output stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: scoreboard of in-flight GRF writers (E..W) driving stall and
// forward selects. Define HZD_MD_EN to add the multiply/divide busy counter and its stall.
module pipe_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int T_W      = 2,
    parameter int N_STG    = 3,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    pipe_hazard_unit_if.slave hz
);
    logic [N_STG:1]    v_reg;
    logic [REG_AW-1:0] addr_reg [1:N_STG];
    logic [T_W-1:0]    tnew_reg [1:N_STG];

    logic [N_STG:1]    rs_match;
    logic [N_STG:1]    rt_match;
    logic              rs_hit, rt_hit;
    logic [2:0]        rs_k, rt_k;
    logic [T_W-1:0]    rs_tnew, rt_tnew;
    logic              stall_rs, stall_rt, stall_md;
    logic              load_ok;

    assign load_ok = !hz.stall && !hz.e_flush;

    // Entry 1 takes the D instruction or a bubble; older entries shift with saturating Tnew.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= N_STG; k++) begin
                v_reg[k]    <= 1'b0;
                addr_reg[k] <= '0;
                tnew_reg[k] <= '0;
            end
        end else begin
            for (int k = N_STG; k >= 2; k--) begin
                v_reg[k]    <= v_reg[k-1];
                addr_reg[k] <= addr_reg[k-1];
                tnew_reg[k] <= (tnew_reg[k-1] == '0) ? '0 : tnew_reg[k-1] - T_W'(1);
            end
            v_reg[1]    <= load_ok && hz.d_valid && hz.d_wr_en && (hz.d_wr_addr != '0);
            addr_reg[1] <= load_ok ? hz.d_wr_addr : '0;
            tnew_reg[1] <= load_ok ? hz.d_tnew : '0;
        end
    end

    generate
        for (genvar gi = 1; gi <= N_STG; gi++) begin : g_match
            assign rs_match[gi] = v_reg[gi] && (addr_reg[gi] == hz.d_rs) && (hz.d_rs != '0);
            assign rt_match[gi] = v_reg[gi] && (addr_reg[gi] == hz.d_rt) && (hz.d_rt != '0);
        end
    endgenerate

    // Scan oldest to youngest so the youngest matching writer overrides.
    always_comb begin
        rs_hit  = 1'b0;
        rs_k    = 3'd0;
        rs_tnew = '0;
        rt_hit  = 1'b0;
        rt_k    = 3'd0;
        rt_tnew = '0;
        for (int k = N_STG; k >= 1; k--) begin
            if (rs_match[k]) begin
                rs_hit  = 1'b1;
                rs_k    = 3'(k);
                rs_tnew = tnew_reg[k];
            end
            if (rt_match[k]) begin
                rt_hit  = 1'b1;
                rt_k    = 3'(k);
                rt_tnew = tnew_reg[k];
            end
        end
    end

    assign stall_rs      = hz.d_valid && rs_hit && (rs_tnew > hz.d_tuse_rs);
    assign stall_rt      = hz.d_valid && rt_hit && (rt_tnew > hz.d_tuse_rt);
    assign hz.stall      = stall_rs || stall_rt || stall_md;
    assign hz.fwd_rs_sel = (rs_hit && !stall_rs && (rs_tnew == '0)) ? rs_k : 3'd0;
    assign hz.fwd_rt_sel = (rt_hit && !stall_rt && (rt_tnew == '0)) ? rt_k : 3'd0;

`ifdef HZD_MD_EN
    logic [4:0] md_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt_reg <= 5'd0;
        end else if (hz.d_valid && hz.d_md_start && load_ok) begin
            md_cnt_reg <= hz.d_md_div ? 5'(DIV_CYC) : 5'(MULT_CYC);
        end else if (md_cnt_reg != 5'd0) begin
            md_cnt_reg <= md_cnt_reg - 5'd1;
        end
    end

    assign hz.md_busy = (md_cnt_reg != 5'd0);
    assign stall_md   = hz.d_valid && hz.d_md_use && hz.md_busy;
`else
    logic md_unused;
    assign md_unused  = ^{hz.d_md_start, hz.d_md_div, hz.d_md_use};
    assign hz.md_busy = 1'b0;
    assign stall_md   = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed-vector bench: stimulus pushes hand-computed expectations into a queue, a monitor
// pops one per check point and compares stall / forward selects / md_busy.
module tb_pipe_hazard_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

`ifdef HZD_MD_EN
    localparam logic MD = 1'b1;
`else
    localparam logic MD = 1'b0;
`endif

    pipe_hazard_unit_if #(.REG_AW(5), .T_W(2)) hz ();

    pipe_hazard_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       stall;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    event chk_now;

    // Monitor: one popped expectation per falling edge (or explicit mid-cycle strobe).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_now);
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (hz.stall !== e.stall || hz.fwd_rs_sel !== e.rs ||
                    hz.fwd_rt_sel !== e.rt || hz.md_busy !== e.busy) begin
                    bad++;
                    $display("FAIL %s: got stall=%0b rs=%0d rt=%0d busy=%0b, want stall=%0b rs=%0d rt=%0d busy=%0b",
                             e.name, hz.stall, hz.fwd_rs_sel, hz.fwd_rt_sel, hz.md_busy,
                             e.stall, e.rs, e.rt, e.busy);
                end else begin
                    $display("ok   %s: stall=%0b rs=%0d rt=%0d busy=%0b",
                             e.name, hz.stall, hz.fwd_rs_sel, hz.fwd_rt_sel, hz.md_busy);
                end
            end
        end
    end

    task automatic expect_out(input string nm, input logic s, input logic [2:0] r,
                              input logic [2:0] t, input logic b);
        exp_t e;
        e.name = nm; e.stall = s; e.rs = r; e.rt = t; e.busy = b;
        q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] ur, input logic [1:0] ut, input logic we,
                         input logic [4:0] wa, input logic [1:0] tn);
        hz.d_valid    = v;
        hz.d_rs       = rs;
        hz.d_rt       = rt;
        hz.d_tuse_rs  = ur;
        hz.d_tuse_rt  = ut;
        hz.d_wr_en    = we;
        hz.d_wr_addr  = wa;
        hz.d_tnew     = tn;
        hz.d_md_start = 1'b0;
        hz.d_md_div   = 1'b0;
        hz.d_md_use   = 1'b0;
        hz.e_flush    = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset_state", 1'b0, 3'd0, 3'd0, 1'b0);
        reset_n = 1'b1;
        next_cycle();

        // lw $3 then addu $4,$3,$3 (tuse=1)
        drive(1'b1, 5'd0, 5'd0, 2'd1, 2'd1, 1'b1, 5'd3, 2'd2);
        expect_out("lw3_issue", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd3, 5'd3, 2'd1, 2'd1, 1'b1, 5'd4, 2'd1);
        expect_out("lw_use_stall", 1'b1, 3'd0, 3'd0, 1'b0);
        next_cycle();
        expect_out("lw_use_release", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();

        // addu $5 then beq $5,$4 (tuse=0)
        drive(1'b1, 5'd0, 5'd0, 2'd1, 2'd1, 1'b1, 5'd5, 2'd1);
        expect_out("addu5_issue", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd5, 5'd4, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
        expect_out("beq_stall_rt_fwdM", 1'b1, 3'd0, 3'd2, 1'b0);
        next_cycle();
        expect_out("beq_fwd_M_W", 1'b0, 3'd2, 3'd3, 1'b0);
        next_cycle();

        // write to $0 then reader of $0
        drive(1'b1, 5'd0, 5'd0, 2'd1, 2'd1, 1'b1, 5'd0, 2'd1);
        expect_out("wr_zero", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
        expect_out("rd_zero", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();

        // lw $6 then ori $6: youngest writer wins
        drive(1'b1, 5'd0, 5'd0, 2'd1, 2'd1, 1'b1, 5'd6, 2'd2);
        expect_out("lw6_issue", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd0, 5'd0, 2'd1, 2'd1, 1'b1, 5'd6, 2'd1);
        expect_out("ori6_issue", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd6, 5'd0, 2'd1, 2'd1, 1'b0, 5'd0, 2'd0);
        expect_out("youngest_E_nofwd", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd6, 5'd6, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
        expect_out("youngest_M_fwd", 1'b0, 3'd2, 3'd2, 1'b0);
        next_cycle();

        // addu $8 then lw $8: younger lw must shadow older ready addu
        drive(1'b1, 5'd0, 5'd0, 2'd1, 2'd1, 1'b1, 5'd8, 2'd1);
        expect_out("addu8_issue", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd0, 5'd0, 2'd1, 2'd1, 1'b1, 5'd8, 2'd2);
        expect_out("lw8_issue", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd8, 5'd0, 2'd1, 2'd1, 1'b0, 5'd0, 2'd0);
        expect_out("shadow_stall", 1'b1, 3'd0, 3'd0, 1'b0);
        next_cycle();
        expect_out("shadow_no_W_fwd", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();

        // flushed writer never reaches the scoreboard
        drive(1'b1, 5'd0, 5'd0, 2'd1, 2'd1, 1'b1, 5'd9, 2'd1);
        hz.e_flush = 1'b1;
        expect_out("flush_issue", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd9, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
        expect_out("after_flush", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();

        // div then mfhi
        drive(1'b1, 5'd0, 5'd0, 2'd1, 2'd1, 1'b0, 5'd0, 2'd0);
        hz.d_md_start = 1'b1;
        hz.d_md_div   = 1'b1;
        hz.d_md_use   = 1'b1;
        expect_out("div_issue", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'd0, 5'd0, 2'd1, 2'd1, 1'b1, 5'd10, 2'd1);
            hz.d_md_use = 1'b1;
            expect_out($sformatf("mfhi_wait%0d", i), MD, 3'd0, 3'd0, MD);
            next_cycle();
        end
        expect_out("mfhi_go", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();

        // reset mid-stall
        drive(1'b1, 5'd0, 5'd0, 2'd1, 2'd1, 1'b1, 5'd3, 2'd2);
        expect_out("rst_lw_issue", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd3, 5'd3, 2'd1, 2'd1, 1'b1, 5'd4, 2'd1);
        expect_out("rst_pre_stall", 1'b1, 3'd0, 3'd0, 1'b0);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        expect_out("rst_async_drop", 1'b0, 3'd0, 3'd0, 1'b0);
        #1;
        -> chk_now;
        #1;
        reset_n = 1'b1;
        next_cycle();
        drive(1'b1, 5'd3, 5'd3, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
        expect_out("rst_sb_empty", 1'b0, 3'd0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending checks, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
